ldpc_c2r_sequencer: RTL and testbench

LDPC_C2R_SEQUENCER -- requirements
Module: ldpc_c2r_sequencer

---
 rtl/ldpc_pkg.sv | 17 +
 rtl/ldpc_credit_counter.sv | 65 ++++++
 rtl/ldpc_c2r_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ldpc_c2r_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared types and constants for the column-to-row sequencer.
//   state_t            - sequencer FSM states
//   COL_W              - width of the column-beat count
//   DEFAULT_FIFO_DEPTH - default number of downstream row-FIFO entries
package ldpc_pkg;

    localparam int COL_W              = 6;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ldpc_credit_counter.sv
// ldpc_credit_counter: saturating up/down counter with misuse flag.
//   clk, rst_n : clock and asynchronous active-low reset (loads RESET_VAL)
//   inc, dec   : step requests; both together leave the count unchanged
//   clear      : synchronous load of zero, overrides inc/dec
//   count      : current registered count
//   err        : single-cycle flag: inc at MAX_VAL or dec at zero (count holds)
module ldpc_credit_counter #(
    parameter int WIDTH     = 6,
    parameter int MAX_VAL   = 63,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             err_s;

    // Next count with saturation at both ends; a blocked step raises err_s.
    always_comb begin
        count_next_s = count_r;
        err_s        = 1'b0;
        if (inc && !dec) begin
            if (count_r == MAX_V) begin
                err_s = 1'b1;
            end else begin
                count_next_s = count_r + ONE_V;
            end
        end else if (dec && !inc) begin
            if (count_r == ZERO_V) begin
                err_s = 1'b1;
            end else begin
                count_next_s = count_r - ONE_V;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register; clear wins over any step in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= RESET_V;
        end else if (clear) begin
            count_r <= ZERO_V;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;
    assign err   = err_s;

endmodule

// File: rtl/ldpc_c2r_sequencer.sv
// ldpc_c2r_sequencer: launches the column beats of one LDPC code block into
// the column-to-row datapath under downstream FIFO credit control, then waits
// for the datapath to drain.
//   i_clock, i_reset : clock, asynchronous active-low reset
//   i_start          : begin one block (accepted only in IDLE)
//   i_num_cols       : column beats in the block, sampled with i_start
//   i_col_valid      : upstream column word present
//   o_col_ready      : upstream ready (RUN with credits left)
//   o_dp_valid       : launch strobe into the datapath
//   o_dp_first/last  : first / last launch of the block
//   i_dp_valid       : one row beat returned by the datapath
//   i_fifo_pop       : downstream FIFO freed one entry
//   o_busy           : not IDLE
//   o_done           : one-cycle block-complete pulse
//   o_error          : sticky fault flag, cleared by an accepted i_start
module ldpc_c2r_sequencer
    import ldpc_pkg::*;
#(
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [COL_W-1:0] i_num_cols,
    input  logic             i_col_valid,
    output logic             o_col_ready,
    output logic             o_dp_valid,
    output logic             o_dp_first,
    output logic             o_dp_last,
    input  logic             i_dp_valid,
    input  logic             i_fifo_pop,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam int                 DRAIN_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [COL_W-1:0]   COL_ZERO   = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);

    state_t             state_r;
    logic [COL_W-1:0]   count_r;
    logic [COL_W-1:0]   launched_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic               error_r;
    logic               done_r;
    logic               busy_r;

    logic [COL_W-1:0]   credits_s;
    logic [COL_W-1:0]   outstanding_s;
    logic               credit_err_s;
    logic               outst_err_s;
    logic               col_ready_s;
    logic               launch_s;
    logic               first_s;
    logic               last_s;
    logic               start_acc_s;
    logic               drain_empty_s;
    logic               timeout_s;
    logic               error_set_s;

    // Ready comes only from registers, so it is low throughout reset.
    assign col_ready_s = (state_r == ST_RUN) && (credits_s != COL_ZERO);
    assign launch_s    = i_col_valid && col_ready_s;
    assign first_s     = (launched_r == COL_ZERO);
    assign last_s      = (launched_r == (count_r - COL_ONE));
    assign start_acc_s = (state_r == ST_IDLE) && i_start;

    // No launches happen in DRAIN, so the next outstanding value is zero when
    // nothing is in flight or the final beat returns this cycle.
    assign drain_empty_s = (outstanding_s == COL_ZERO) ||
                           ((outstanding_s == COL_ONE) && i_dp_valid);
    assign timeout_s     = (state_r == ST_DRAIN) && !drain_empty_s &&
                           (drain_cnt_r == DRAIN_LAST);
    assign error_set_s   = credit_err_s || outst_err_s || timeout_s;

    // Free downstream FIFO entries; persists across blocks.
    ldpc_credit_counter #(
        .WIDTH     (COL_W),
        .MAX_VAL   (FIFO_DEPTH),
        .RESET_VAL (FIFO_DEPTH)
    ) u_credits (
        .clk   (i_clock),
        .rst_n (i_reset),
        .inc   (i_fifo_pop),
        .dec   (launch_s),
        .clear (1'b0),
        .count (credits_s),
        .err   (credit_err_s)
    );

    // Launches still owed a row beat by the datapath; dropped on timeout.
    ldpc_credit_counter #(
        .WIDTH     (COL_W),
        .MAX_VAL   ((1 << COL_W) - 1),
        .RESET_VAL (0)
    ) u_outstanding (
        .clk   (i_clock),
        .rst_n (i_reset),
        .inc   (launch_s),
        .dec   (i_dp_valid),
        .clear (timeout_s),
        .count (outstanding_s),
        .err   (outst_err_s)
    );

    // Sequencer FSM with registered busy/done/error.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            count_r     <= COL_ZERO;
            launched_r  <= COL_ZERO;
            drain_cnt_r <= DRAIN_ZERO;
            error_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // A fault in the same cycle as a start still gets recorded.
            error_r <= error_set_s || (error_r && !start_acc_s);
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_start) begin
                        count_r    <= i_num_cols;
                        launched_r <= COL_ZERO;
                        busy_r     <= 1'b1;
                        if (i_num_cols != COL_ZERO) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (launch_s) begin
                        launched_r <= launched_r + COL_ONE;
                        if (last_s) begin
                            state_r     <= ST_DRAIN;
                            drain_cnt_r <= DRAIN_ZERO;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_col_ready = col_ready_s;
    assign o_dp_valid  = launch_s;
    assign o_dp_first  = launch_s && first_s;
    assign o_dp_last   = launch_s && last_s;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_error     = error_r;

endmodule

// File: tb/tb_ldpc_c2r_sequencer.sv
module tb_ldpc_c2r_sequencer;

    localparam int FD = 16;
    localparam int DT = 32;

    localparam logic [3:0] P_READY   = 4'd0;
    localparam logic [3:0] P_DPV     = 4'd1;
    localparam logic [3:0] P_FIRST   = 4'd2;
    localparam logic [3:0] P_LAST    = 4'd3;
    localparam logic [3:0] P_BUSY    = 4'd4;
    localparam logic [3:0] P_DONE    = 4'd5;
    localparam logic [3:0] P_ERROR   = 4'd6;
    localparam logic [3:0] P_DRAINED = 4'd7;

    logic       i_clock     = 1'b0;
    logic       i_reset     = 1'b0;
    logic       i_start     = 1'b0;
    logic [5:0] i_num_cols  = 6'd0;
    logic       i_col_valid = 1'b0;
    logic       i_fifo_pop  = 1'b0;
    logic       i_dp_valid;
    logic       o_col_ready, o_dp_valid, o_dp_first, o_dp_last;
    logic       o_busy, o_done, o_error;

    typedef struct packed { logic first; logic last; } beat_t;
    typedef struct packed { logic [3:0] kind; logic exp; } probe_t;

    beat_t  exp_q[$];
    int     exp_done_q[$];
    probe_t probe_q[$];

    int checks = 0;
    int passes = 0;
    int done_seen = 0;
    int launches_since = 0;

    // datapath / FIFO model state
    logic [7:0] dp_pipe = 8'd0;
    logic [2:0] lat_sel = 3'd0;
    int occ = 0;
    int total_launches = 0;
    int drop_at = -1;

    // stimulus knobs
    int   pop_mode = 0;
    logic col_rand = 1'b0;
    logic col_hold = 1'b0;

    always #5 i_clock = ~i_clock;

    ldpc_c2r_sequencer #(.FIFO_DEPTH(FD), .DRAIN_TIMEOUT(DT)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_num_cols  (i_num_cols),
        .i_col_valid (i_col_valid),
        .o_col_ready (o_col_ready),
        .o_dp_valid  (o_dp_valid),
        .o_dp_first  (o_dp_first),
        .o_dp_last   (o_dp_last),
        .i_dp_valid  (i_dp_valid),
        .i_fifo_pop  (i_fifo_pop),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    // Datapath: one row beat per launch after lat_sel+1 cycles (optionally
    // dropping one); FIFO occupancy = launches minus pops.
    always @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            occ     <= 0;
            dp_pipe <= 8'd0;
        end else begin
            occ     <= occ + int'(o_dp_valid) - int'(i_fifo_pop);
            dp_pipe <= {dp_pipe[6:0], o_dp_valid && (total_launches != drop_at)};
        end
    end

    always @(posedge i_clock) begin
        if (o_dp_valid) total_launches <= total_launches + 1;
    end

    assign i_dp_valid = dp_pipe[lat_sel];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    endtask

    // Monitor / scoreboard
    always @(negedge i_clock) begin
        probe_t p;
        beat_t  b;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.kind)
                P_READY: chk("col_ready", int'(o_col_ready), int'(p.exp));
                P_DPV:   chk("dp_valid",  int'(o_dp_valid),  int'(p.exp));
                P_FIRST: chk("dp_first",  int'(o_dp_first),  int'(p.exp));
                P_LAST:  chk("dp_last",   int'(o_dp_last),   int'(p.exp));
                P_BUSY:  chk("busy",      int'(o_busy),      int'(p.exp));
                P_DONE:  chk("done",      int'(o_done),      int'(p.exp));
                P_ERROR: chk("error",     int'(o_error),     int'(p.exp));
                P_DRAINED: begin
                    chk("launches_left", exp_q.size(), 0);
                    chk("dones_left", exp_done_q.size(), 0);
                end
                default: begin end
            endcase
        end
        if (o_dp_valid) begin
            launches_since++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_launch: dp_valid 1 with no launch expected at %0t", $time);
            end else begin
                b = exp_q.pop_front();
                chk("launch_first", int'(o_dp_first), int'(b.first));
                chk("launch_last",  int'(o_dp_last),  int'(b.last));
            end
        end
        if (o_done) begin
            done_seen++;
            if (exp_done_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done 1 with no block completion expected at %0t", $time);
            end else begin
                chk("done_beats", launches_since, exp_done_q.pop_front());
            end
        end
        if (!o_busy) launches_since = 0;
    end

    task automatic probe(input logic [3:0] k, input logic e);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        probe_q.push_back(p);
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        case (pop_mode)
            1:       i_fifo_pop = (occ > 0);
            2:       i_fifo_pop = (occ > 0) && ($urandom_range(0, 1) == 1);
            default: i_fifo_pop = 1'b0;
        endcase
        i_col_valid = col_rand ? ($urandom_range(0, 1) == 1) : col_hold;
        // A full downstream FIFO must hold off every launch.
        if (occ >= FD) probe(P_READY, 1'b0);
    endtask

    task automatic start_block(input int n, input bit expect_done);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.first = (i == 0);
            b.last  = (i == n - 1);
            exp_q.push_back(b);
        end
        if (expect_done) exp_done_q.push_back(n);
        i_num_cols = 6'(n);
        i_start    = 1'b1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        exp_q.delete();
        exp_done_q.delete();
        probe(P_READY, 1'b0); probe(P_DPV, 1'b0); probe(P_FIRST, 1'b0);
        probe(P_LAST, 1'b0);  probe(P_BUSY, 1'b0); probe(P_DONE, 1'b0);
        probe(P_ERROR, 1'b0);
        step();
        step();
        i_reset = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_seen;
        k  = 0;
        while (done_seen == d0 && k < budget) begin
            step();
            k++;
        end
        if (done_seen == d0) probe(P_DONE, 1'b1);
    endtask

    initial begin
        int n;
        int base;
        int d0;
        int k;

        do_reset();

        // Four beats, valid held, immediate pops.
        pop_mode = 1; col_rand = 1'b0; col_hold = 1'b1; lat_sel = 3'd0;
        step(); start_block(4, 1'b1); probe(P_BUSY, 1'b0); probe(P_READY, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            step();
            probe(P_DPV, c <= 4);
            probe(P_DONE, c == 6);
            probe(P_BUSY, c <= 6);
        end

        // Single-beat block: first and last together.
        step(); start_block(1, 1'b1);
        step(); probe(P_DPV, 1'b1); probe(P_FIRST, 1'b1); probe(P_LAST, 1'b1);
        step(); probe(P_DPV, 1'b0);
        step(); probe(P_DONE, 1'b1);
        step(); probe(P_DONE, 1'b0);

        // Zero-beat block.
        step(); start_block(0, 1'b1); probe(P_BUSY, 1'b0);
        step(); probe(P_BUSY, 1'b1); probe(P_DONE, 1'b1); probe(P_DPV, 1'b0);
        step(); probe(P_BUSY, 1'b0); probe(P_DONE, 1'b0);

        // Random back-to-back blocks; FIFO occupancy carries over.
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 40);
            lat_sel = 3'($urandom_range(0, 3));
            pop_mode = 2; col_rand = 1'b1;
            d0 = done_seen;
            step(); start_block(n, 1'b1);
            base = total_launches;
            k = 0;
            do begin
                step();
                k++;
                if (done_seen == d0 && (total_launches - base) < n)
                    probe(P_READY, occ < FD);
            end while (done_seen == d0 && k < 1000);
            if (done_seen == d0) probe(P_DONE, 1'b1);
            probe(P_ERROR, 1'b0);
        end
        step(); probe(P_DRAINED, 1'b0);

        // Dropped row beat: timeout after DT drain cycles, no done.
        do_reset();
        pop_mode = 1; col_rand = 1'b0; col_hold = 1'b1; lat_sel = 3'd0;
        step(); start_block(4, 1'b0);
        drop_at = total_launches + 1;
        for (int c = 1; c <= 37; c++) begin
            step();
            probe(P_DONE, 1'b0);
            if (c == 36) begin probe(P_ERROR, 1'b0); probe(P_BUSY, 1'b1); end
            if (c == 37) begin probe(P_ERROR, 1'b1); probe(P_BUSY, 1'b0); end
        end
        drop_at = -1;
        step(); start_block(1, 1'b1); probe(P_ERROR, 1'b1);
        step(); probe(P_ERROR, 1'b0); probe(P_DPV, 1'b1);
        wait_done(10);

        // Reset in the middle of a block after two launches.
        step(); start_block(5, 1'b1);
        step(); probe(P_DPV, 1'b1);
        step(); probe(P_DPV, 1'b1);
        step(); do_reset();

        // Credits restored to FD: 16 launches, then one per pop.
        pop_mode = 0; col_hold = 1'b1;
        step(); start_block(20, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            step(); probe(P_DPV, 1'b1);
        end
        for (int c = 17; c <= 19; c++) begin
            step(); probe(P_DPV, 1'b0); probe(P_READY, 1'b0);
        end
        step(); i_fifo_pop = 1'b1; probe(P_DPV, 1'b0);
        step(); probe(P_DPV, 1'b1);
        step(); probe(P_DPV, 1'b0); probe(P_READY, 1'b0);
        step(); probe(P_DPV, 1'b0); probe(P_ERROR, 1'b0);
        step();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
